fft8_bitrev_reorder: RTL and testbench

- Consumer-side companion of the serial 8-point FFT.
- The FFT emits each 8-sample frame in bit-reversed frequency order. This block buffers each frame and re-emits it in natural order (bin 0..7).
- Ping-pong storage of two 8-entry banks, valid/ready handshake on both sides, so the FFT can stream continuously while the downstream stage stalls.

---
 rtl/fft8_bitrev_reorder.sv | 122 ++++++++++++
 tb/tb_fft8_bitrev_reorder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_bitrev_reorder.sv
// fft8_bitrev_reorder: ping-pong buffer that turns the bit-reversed output of an 8-point FFT into natural bin order.
// Optional FFT8_REORDER_SOF_EN adds in_sof framing and a sticky frame_err flag. Rev 1.0
`default_nettype none

module fft8_bitrev_reorder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
`ifdef FFT8_REORDER_SOF_EN
  input  logic         in_sof,
  output logic         frame_err,
`endif
  input  logic         out_ready
);

  function automatic logic [2:0] bitrev3(input logic [2:0] b);
    return {b[0], b[1], b[2]};
  endfunction

  logic [W-1:0] mem [2][8];
  logic [1:0]   full;
  logic         wr_bank;
  logic         rd_bank;
  logic [2:0]   wr_cnt;
  logic [2:0]   rd_cnt;

  logic         wr_fire;
  logic         rd_fire;
  logic         wr_en;
  logic [2:0]   wr_idx;
  logic         wr_done;
  logic         rd_done;
  logic         sof_err;
  logic [1:0]   set_mask;
  logic [1:0]   clr_mask;

  assign in_ready  = ~full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_data  = out_valid ? mem[rd_bank][rd_cnt] : '0;
  assign out_last  = out_valid & (rd_cnt == 3'd7);

  assign wr_fire = in_valid & in_ready;
  assign rd_fire = out_valid & out_ready;

  // Framing decision: which slot (if any) the accepted sample lands in.
  always_comb begin
    wr_en   = wr_fire;
    wr_idx  = wr_cnt;
    sof_err = 1'b0;
`ifdef FFT8_REORDER_SOF_EN
    if (wr_fire && in_sof && (wr_cnt != 3'd0)) begin
      wr_idx  = 3'd0;
      sof_err = 1'b1;
    end else if (wr_fire && !in_sof && (wr_cnt == 3'd0)) begin
      wr_en   = 1'b0;
      sof_err = 1'b1;
    end
`endif
  end

  assign wr_done  = wr_en & (wr_idx == 3'd7);
  assign rd_done  = rd_fire & (rd_cnt == 3'd7);
  assign set_mask = wr_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign clr_mask = rd_done ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][bitrev3(wr_idx)] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= 3'd0;
      rd_cnt  <= 3'd0;
    end else begin
      // Write and read always target different banks, so both masks may apply.
      full <= (full | set_mask) & ~clr_mask;
      if (wr_en) begin
        wr_cnt <= wr_idx + 3'd1;
      end
      if (wr_done) begin
        wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 3'd1;
      end
      if (rd_done) begin
        rd_bank <= ~rd_bank;
      end
    end
  end

`ifdef FFT8_REORDER_SOF_EN
  logic err_q;
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      err_q <= 1'b0;
    end else if (sof_err) begin
      err_q <= 1'b1;
    end
  end
  assign frame_err = err_q;
`else
  logic unused_sof_err;
  assign unused_sof_err = sof_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft8_bitrev_reorder.sv
// tb_fft8_bitrev_reorder: table-driven single-frame check plus model-based directed and random tests.
`default_nettype none

module tb_fft8_bitrev_reorder;

  logic       clk;
  logic       clear;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
`ifdef FFT8_REORDER_SOF_EN
  logic       in_sof;
  logic       frame_err;
  bit         sof_force;
  bit         sof_val;
  bit         m_err;
`endif

  int checks;
  int failures;

  fft8_bitrev_reorder #(.W(8)) dut (
    .clk       (clk),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef FFT8_REORDER_SOF_EN
    .in_sof    (in_sof),
    .frame_err (frame_err),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         iv;
    logic [7:0] d;
    bit         ordy;
    bit         e_ready;
    bit         e_valid;
    logic [7:0] e_data;
    bit         e_last;
  } vec_t;

  vec_t vecs[17];
  int   nat_order[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  // Reference model: completed frames become a queue of natural-order outputs.
  logic [7:0] exp_q[$];
  bit         exp_last_q[$];
  logic [7:0] part[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bitrev(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_last_q.delete();
    part.delete();
`ifdef FFT8_REORDER_SOF_EN
    m_err = 1'b0;
`endif
  endtask

  task automatic tick(input bit v, input logic [7:0] d, input bit r);
    int  frames;
    bit  acc;
    bit  sof;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    sof = 1'b0;
`ifdef FFT8_REORDER_SOF_EN
    sof    = sof_force ? sof_val : (part.size() == 0);
    in_sof = sof;
`endif
    @(negedge clk);
    frames = (exp_q.size() + 7) / 8;
    chk("in_ready", in_ready, frames < 2);
    chk("out_valid", out_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      chk("out_data", out_data, exp_q[0]);
      chk("out_last", out_last, exp_last_q[0]);
    end else begin
      chk("out_data_idle", out_data, 0);
      chk("out_last_idle", out_last, 0);
    end
`ifdef FFT8_REORDER_SOF_EN
    chk("frame_err", frame_err, m_err);
`endif
    acc = v && (frames < 2);
    if (r && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      void'(exp_last_q.pop_front());
    end
    if (acc) begin
`ifdef FFT8_REORDER_SOF_EN
      if (sof && part.size() != 0) begin
        m_err = 1'b1;
        part.delete();
        part.push_back(d);
      end else if (!sof && part.size() == 0) begin
        m_err = 1'b1;
      end else begin
        part.push_back(d);
      end
`else
      part.push_back(d);
`endif
      if (part.size() == 8) begin
        for (int k = 0; k < 8; k++) begin
          exp_q.push_back(part[bitrev(k)]);
          exp_last_q.push_back(k == 7);
        end
        part.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
`ifdef FFT8_REORDER_SOF_EN
    chk("rst_frame_err", frame_err, 0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    clear     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
`ifdef FFT8_REORDER_SOF_EN
    in_sof    = 1'b0;
    sof_force = 1'b0;
    sof_val   = 1'b0;
    m_err     = 1'b0;
`endif

    for (int k = 0; k < 17; k++) begin
      vecs[k].iv      = (k < 8);
      vecs[k].d       = (k < 8) ? 8'(8'h10 + k) : 8'h00;
      vecs[k].ordy    = 1'b1;
      vecs[k].e_ready = 1'b1;
      vecs[k].e_valid = (k >= 8) && (k < 16);
      vecs[k].e_data  = ((k >= 8) && (k < 16)) ? 8'(8'h10 + nat_order[k - 8]) : 8'h00;
      vecs[k].e_last  = (k == 15);
    end

    @(posedge clk);
    do_reset();

    // Single frame, table driven.
    for (int k = 0; k < 17; k++) begin
      in_valid  = vecs[k].iv;
      in_data   = vecs[k].d;
      out_ready = vecs[k].ordy;
`ifdef FFT8_REORDER_SOF_EN
      in_sof    = (k == 0);
`endif
      @(negedge clk);
      chk("tbl_in_ready", in_ready, vecs[k].e_ready);
      chk("tbl_out_valid", out_valid, vecs[k].e_valid);
      chk("tbl_out_data", out_data, vecs[k].e_data);
      chk("tbl_out_last", out_last, vecs[k].e_last);
      @(posedge clk);
      #1;
    end

    do_reset();
    // Four back-to-back frames with a free-running consumer.
    for (int k = 0; k < 32; k++) tick(1'b1, 8'(k), 1'b1);
    for (int k = 0; k < 10; k++) tick(1'b0, 8'h00, 1'b1);

    // Backpressure: both banks fill, then drain while the writer keeps pushing.
    for (int k = 0; k < 17; k++) tick(1'b1, 8'(8'h20 + k), 1'b0);
    for (int k = 0; k < 12; k++) tick(1'b1, 8'(8'h30 + k), 1'b1);
    for (int k = 0; k < 4; k++) tick(1'b1, 8'(8'h3C + k), 1'b1);
    for (int k = 0; k < 20; k++) tick(1'b0, 8'h00, 1'b1);

    // Stall hold pattern during drain.
    for (int k = 0; k < 8; k++) tick(1'b1, 8'(8'h90 + k), 1'b0);
    for (int k = 0; k < 16; k++) tick(1'b0, 8'h00, (k % 4 == 0) || (k % 4 == 3));

    // Reset with one full frame pending and a partial frame in flight.
    for (int k = 0; k < 8; k++) tick(1'b1, 8'(8'h50 + k), 1'b0);
    for (int k = 0; k < 5; k++) tick(1'b1, 8'(8'h60 + k), 1'b0);
    do_reset();
    for (int k = 0; k < 8; k++) tick(1'b1, 8'(8'h40 + k), 1'b1);
    for (int k = 0; k < 9; k++) tick(1'b0, 8'h00, 1'b1);

`ifdef FFT8_REORDER_SOF_EN
    // Early start-of-frame on the 4th sample restarts the frame.
    sof_force = 1'b1;
    for (int k = 0; k < 11; k++) begin
      sof_val = (k == 0) || (k == 3);
      tick(1'b1, 8'(8'h70 + k), 1'b1);
    end
    for (int k = 0; k < 8; k++) begin
      sof_val = (k == 0);
      tick(1'b1, 8'(8'h80 + k), 1'b1);
    end
    sof_val = 1'b0;
    for (int k = 0; k < 10; k++) tick(1'b0, 8'h00, 1'b1);
    chk("sof_err_sticky", frame_err, 1);
    sof_force = 1'b0;
    do_reset();
`endif

    // Randomised traffic against the model.
    for (int k = 0; k < 500; k++) begin
      tick(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0);
    end
    for (int k = 0; k < 20; k++) tick(1'b0, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
